multiplicador: RTL and testbench
================================

MULTIPLICADOR -- requirements
Module: multiplicador

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits; it SHALL be verified at N=8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port load, input, 1 bit: start request, sampled on the rising clk edge.
REQ-005 The block SHALL have port x, input, N bits: the multiplicand.
REQ-006 The block SHALL have port y, input, N bits: the multiplier.
REQ-007 The block SHALL have port A, output, N bits: the upper half of the product and the running accumulator.
REQ-008 The block SHALL have port MQ, output, N bits: the lower half of the product and the multiplier shift register.
REQ-009 The block SHALL have port busy, output, 1 bit: high while iterations are in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when {A,MQ} holds the final product.

Function
REQ-011 The block SHALL use three states, IDLE, RUN and FIN, held in a registered state machine.
REQ-012 When load=1 at an edge, the block SHALL perform all of the following in that edge, from any state:
- capture M=x;
- clear the internal accumulator (N+1 bits) to 0;
- set MQ=y and q_1=0;
- set the iteration count to N;
- go to RUN with busy=1 and done=0.
REQ-013 In RUN, the block SHALL perform exactly one iteration per edge, first the add/subtract step defined in Configuration and then a one-bit right shift of {accumulator,MQ,q_1}, and SHALL decrement the count.
REQ-014 The internal accumulator SHALL be N+1 bits wide so that adding or subtracting M never overflows (this covers x=-2^(N-1)); the A output SHALL be the accumulator's low N bits.
REQ-015 On the edge that completes iteration N, the block SHALL go to FIN with busy=0 and done=1.
REQ-016 If load=0 in FIN, the next edge SHALL return the block to IDLE with done=0.
REQ-017 Latency SHALL be as follows: load sampled at edge k gives the final product on {A,MQ} and done=1 after edge k+N. This is N cycles, with no dependence on the data.
REQ-018 In IDLE and FIN, A and MQ SHALL hold the last product unchanged until the next load or reset.
REQ-019 A load while busy=1 SHALL abort the current operation and restart with the new operands; no done pulse SHALL be produced for the aborted operation.
REQ-020 A load in the FIN cycle SHALL start a new operation; done SHALL then fall on that same edge.
REQ-021 x and y SHALL be ignored at every edge except a load edge.

Reset
REQ-022 When rst_n=0 at an edge, the block SHALL set: state=IDLE, A=0, MQ=0, accumulator=0, M=0, q_1=0, count=0, busy=0, done=0.
REQ-023 rst_n=0 SHALL take priority over load, and SHALL abort any operation in progress with no done pulse.
REQ-024 After rst_n returns to 1, the block SHALL remain in IDLE until a load.

Configuration
REQ-025 The feature selection SHALL use macro MULTIPLICADOR_SIGNED_EN.
REQ-026 With MULTIPLICADOR_SIGNED_EN defined, the block SHALL implement radix-2 Booth multiplication of two's-complement operands:
- M SHALL be sign-extended to N+1 bits;
- when {MQ[0],q_1} is 01, the accumulator SHALL be increased by M;
- when {MQ[0],q_1} is 10, M SHALL be subtracted from the accumulator;
- the shift SHALL be arithmetic (sign bit replicated);
- {A,MQ} SHALL be the 2N-bit signed product.
REQ-027 With MULTIPLICADOR_SIGNED_EN undefined, the block SHALL implement unsigned shift-add multiplication:
- M SHALL be zero-extended;
- when MQ[0]=1, the accumulator SHALL be increased by M, with bit N holding the carry;
- the shift SHALL be logical, bringing the carry into A[N-1];
- q_1 SHALL be unused;
- {A,MQ} SHALL be the 2N-bit unsigned product.
REQ-028 Latency and handshake SHALL be identical in both builds.

Verification
REQ-029 Both builds: x=27, y=4, load for 1 cycle -> done after edge k+8, A=0x00, MQ=0x6C, busy high for exactly 8 cycles.
REQ-030 Signed build: x=-5 (0xFB), y=3 -> {A,MQ}=0xFFF1; x=-128, y=-128 -> {A,MQ}=0x4000.
REQ-031 Unsigned build: x=255, y=255 -> {A,MQ}=0xFE01; x=0, y=200 -> {A,MQ}=0x0000 with done still pulsed at k+8.
REQ-032 Restart: x=13, y=3 loaded, then load x=50, y=10 at iteration 4 -> exactly one done pulse, 8 cycles after the second load, {A,MQ}=0x01F4.
REQ-033 Reset mid-operation: rst_n=0 at iteration 5 -> next cycle A=0, MQ=0, busy=0, done=0; no done pulse afterward until a new load.
REQ-034 Back-to-back: load asserted in the FIN cycle of 32*8 -> done pulses for 0x0100, then 8 cycles later for the second product, with no lost or extra pulse.

Source files
------------

// File: rtl/multiplicador_if.sv
// Handshake and data bundle for the sequential multiplicador.
interface multiplicador_if #(
    parameter int N = 8
);
    logic         load;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] A;
    logic [N-1:0] MQ;
    logic         busy;
    logic         done;

    modport master (output load, x, y, input A, MQ, busy, done);
    modport slave  (input load, x, y, output A, MQ, busy, done);
endinterface

// File: rtl/multiplicador.sv
// N-cycle iterative multiplier; product appears on {A,MQ}.
// Define MULTIPLICADOR_SIGNED_EN for radix-2 Booth (two's complement), else unsigned shift-add.
module multiplicador #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    multiplicador_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state, state_d;
    logic [N:0]    acc, acc_d;
    logic [N-1:0]  mq, mq_d;
    logic [N-1:0]  m, m_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [N:0]    mext;
    logic [N:0]    sum;
    logic [N:0]    acc_sh;
`ifdef MULTIPLICADOR_SIGNED_EN
    logic          q1, q1_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            mq    <= '0;
            m     <= '0;
            cnt   <= '0;
`ifdef MULTIPLICADOR_SIGNED_EN
            q1    <= 1'b0;
`endif
        end else begin
            state <= state_d;
            acc   <= acc_d;
            mq    <= mq_d;
            m     <= m_d;
            cnt   <= cnt_d;
`ifdef MULTIPLICADOR_SIGNED_EN
            q1    <= q1_d;
`endif
        end
    end

    // Add/subtract step followed by the one-bit right shift of the accumulator.
    always_comb begin
`ifdef MULTIPLICADOR_SIGNED_EN
        mext = {m[N-1], m};
        case ({mq[0], q1})
            2'b01:   sum = acc + mext;
            2'b10:   sum = acc - mext;
            default: sum = acc;
        endcase
        acc_sh = {sum[N], sum[N:1]};
`else
        mext   = {1'b0, m};
        sum    = mq[0] ? (acc + mext) : acc;
        acc_sh = {1'b0, sum[N:1]};
`endif
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        mq_d    = mq;
        m_d     = m;
        cnt_d   = cnt;
`ifdef MULTIPLICADOR_SIGNED_EN
        q1_d    = q1;
`endif
        case (state)
            IDLE: state_d = IDLE;
            RUN: begin
                acc_d = acc_sh;
                mq_d  = {sum[0], mq[N-1:1]};
`ifdef MULTIPLICADOR_SIGNED_EN
                q1_d  = mq[0];
`endif
                cnt_d = cnt - 1'b1;
                if (cnt == CW'(1))
                    state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A load overrides whatever the current state would do, including an in-flight run.
        if (bus.load) begin
            m_d     = bus.x;
            acc_d   = '0;
            mq_d    = bus.y;
`ifdef MULTIPLICADOR_SIGNED_EN
            q1_d    = 1'b0;
`endif
            cnt_d   = CW'(N);
            state_d = RUN;
        end
    end

    assign bus.A    = acc[N-1:0];
    assign bus.MQ   = mq;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == FIN);
endmodule

// File: tb/tb_multiplicador.sv
// Directed self-checking bench for multiplicador at N=8 (either build).
module tb_multiplicador;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multiplicador_if #(.N(8)) bus ();

    multiplicador #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load for one edge; busy must rise and done must be low on that edge.
    task automatic start(input logic [7:0] xv, input logic [7:0] yv, input string tag);
        bus.load = 1'b1;
        bus.x    = xv;
        bus.y    = yv;
        tick();
        bus.load = 1'b0;
        bus.x    = 8'($urandom);
        bus.y    = 8'($urandom);
        chk({tag, " busy@load"}, 32'(bus.busy), 32'd1);
        chk({tag, " done@load"}, 32'(bus.done), 32'd0);
    endtask

    // Seven more busy edges, then done with the product on the eighth edge after load.
    task automatic finish(input logic [15:0] prod, input string tag, input bit leave_fin);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("%s busy@%0d", tag, i), 32'(bus.busy), 32'd1);
            chk($sformatf("%s done@%0d", tag, i), 32'(bus.done), 32'd0);
        end
        tick();
        chk({tag, " done@8"}, 32'(bus.done), 32'd1);
        chk({tag, " busy@8"}, 32'(bus.busy), 32'd0);
        chk({tag, " product"}, 32'({bus.A, bus.MQ}), 32'(prod));
        if (leave_fin) begin
            tick();
            chk({tag, " done fall"}, 32'(bus.done), 32'd0);
            chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
            chk({tag, " hold"}, 32'({bus.A, bus.MQ}), 32'(prod));
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        bus.x    = 8'h00;
        bus.y    = 8'h00;
        tick();
        tick();
        chk("reset A", 32'(bus.A), 32'd0);
        chk("reset MQ", 32'(bus.MQ), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle after reset", 32'(bus.busy), 32'd0);

        start(8'd27, 8'd4, "27x4");
        finish(16'h006C, "27x4", 1'b1);

`ifdef MULTIPLICADOR_SIGNED_EN
        start(8'hFB, 8'd3, "-5x3");
        finish(16'hFFF1, "-5x3", 1'b1);
        start(8'h80, 8'h80, "-128x-128");
        finish(16'h4000, "-128x-128", 1'b1);
        start(8'd3, 8'hFF, "3x-1");
        finish(16'hFFFD, "3x-1", 1'b1);
`else
        start(8'd255, 8'd255, "255x255");
        finish(16'hFE01, "255x255", 1'b1);
        start(8'd0, 8'd200, "0x200");
        finish(16'h0000, "0x200", 1'b1);
        start(8'd200, 8'd3, "200x3");
        finish(16'h0258, "200x3", 1'b1);
`endif

        // Abort at iteration 4 by a fresh load; only the second operation may complete.
        start(8'd13, 8'd3, "restart1");
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("restart1 done@%0d", i), 32'(bus.done), 32'd0);
        end
        start(8'd50, 8'd10, "restart2");
        finish(16'h01F4, "restart2", 1'b1);

        // Reset at iteration 5 aborts with no later done pulse.
        start(8'd99, 8'd77, "midreset");
        for (int i = 1; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset A", 32'(bus.A), 32'd0);
        chk("midreset MQ", 32'(bus.MQ), 32'd0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("postreset done@%0d", i), 32'(bus.done), 32'd0);
            chk($sformatf("postreset busy@%0d", i), 32'(bus.busy), 32'd0);
        end

        // Back-to-back: load during the FIN cycle of the first product.
        start(8'd32, 8'd8, "b2b1");
        finish(16'h0100, "b2b1", 1'b0);
        start(8'd7, 8'd9, "b2b2");
        finish(16'h003F, "b2b2", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
